// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the data cache.
package dcache_pkg;

    localparam int WORD_W          = 32;
    localparam int DEF_SETS        = 16;
    localparam int DEF_LINE_WORDS  = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    // Tag field: everything above index and word offset.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int idx_w,
                                             input int off_w);
        return addr >> (2 + off_w + idx_w);
    endfunction

    // Line index field.
    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int idx_w,
                                               input int off_w);
        return (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Word-within-line field; byte offset bits [1:0] are dropped.
    function automatic logic [31:0] addr_word(input logic [31:0] addr,
                                              input int off_w);
        return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Pipeline-side and memory-side bundles of the data cache.
interface dcache_cpu_if;
    import dcache_pkg::*;

    logic              Wen;
    logic              Ren;
    logic [WORD_W-1:0] Addr;
    logic [WORD_W-1:0] WriteData;
    logic [WORD_W-1:0] ReadData;
    logic              Stall;

    // master = memory stage, slave = cache
    modport master (output Wen, Ren, Addr, WriteData, input ReadData, Stall);
    modport slave  (input Wen, Ren, Addr, WriteData, output ReadData, Stall);
endinterface

interface dcache_mem_if;
    import dcache_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ready;

    // master = cache, slave = main memory
    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_array.sv
// Line storage: valid/dirty flags, tags and data words, one read and one write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int IDX_W      = $clog2(SETS),
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = 30 - IDX_W - OFF_W
) (
    input  logic              clk,
    input  logic              reset,
    // read port
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [OFF_W-1:0]  rd_word,
    output logic [WORD_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    // write port
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [OFF_W-1:0]  wr_word,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              we_data,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              we_tag,
    input  logic              wr_valid,
    input  logic              wr_dirty,
    input  logic              we_flags
);

    logic [WORD_W-1:0] data_mem [SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;

    assign rd_data  = data_mem[rd_index][rd_word];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];

    // Data and tag storage; not reset, contents only matter once a line is valid.
    always_ff @(posedge clk) begin
        if (we_data) begin
            data_mem[wr_index][wr_word] <= wr_data;
        end
        if (we_tag) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    // Line flags; reset invalidates every line, including one caught mid-refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_flags) begin
            valid_q[wr_index] <= wr_valid;
            dirty_q[wr_index] <= wr_dirty;
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back write-allocate data cache with word-serial line transfers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | serve hits combinationally; a miss stalls and picks a path
// WRITEBACK | stream the dirty victim line out, word cnt per ready beat
// REFILL    | stream the requested line in, install tag on last beat
module dcache
    import dcache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic         clk,
    input  logic         reset,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_index;
    logic [OFF_W-1:0]  req_word;
    logic              access;
    logic              hit;

    logic [OFF_W-1:0]  rd_word;
    logic [WORD_W-1:0] rd_data;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              rd_dirty;

    logic [OFF_W-1:0]  wr_word;
    logic [WORD_W-1:0] wr_data;
    logic              we_data;
    logic              we_tag;
    logic              wr_valid;
    logic              wr_dirty;
    logic              we_flags;

    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;

    assign req_tag   = TAG_W'(addr_tag(cpu.Addr, IDX_W, OFF_W));
    assign req_index = IDX_W'(addr_index(cpu.Addr, IDX_W, OFF_W));
    assign req_word  = OFF_W'(addr_word(cpu.Addr, OFF_W));
    assign access    = cpu.Wen | cpu.Ren;
    assign hit       = rd_valid && (rd_tag == req_tag);

    dcache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (req_index),
        .rd_word  (rd_word),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .wr_index (req_index),
        .wr_word  (wr_word),
        .wr_data  (wr_data),
        .we_data  (we_data),
        .wr_tag   (req_tag),
        .we_tag   (we_tag),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty),
        .we_flags (we_flags)
    );

    // State and word counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, array write controls and memory-side drive.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        rd_word  = req_word;
        wr_word  = req_word;
        wr_data  = cpu.WriteData;
        we_data  = 1'b0;
        we_tag   = 1'b0;
        we_flags = 1'b0;
        wr_valid = 1'b0;
        wr_dirty = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        // Wen wins when both strobes are set.
                        if (cpu.Wen) begin
                            we_data  = 1'b1;
                            we_flags = 1'b1;
                            wr_valid = 1'b1;
                            wr_dirty = 1'b1;
                        end
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = '0;
                        state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
                    end
                end
            end

            WRITEBACK: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                rd_word  = cnt_q;
                mem_addr = {rd_tag, req_index, cnt_q, 2'b00};
                if (mem.mem_ready) begin
                    cnt_d = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = REFILL;
                    end
                end
            end

            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_index, cnt_q, 2'b00};
                if (mem.mem_ready) begin
                    we_data = 1'b1;
                    wr_word = cnt_q;
                    wr_data = mem.mem_rdata;
                    cnt_d   = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        // Install the line clean; a pending store dirties it on retry.
                        we_tag   = 1'b1;
                        we_flags = 1'b1;
                        wr_valid = 1'b1;
                        wr_dirty = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu.ReadData  = rd_data;
    assign cpu.Stall     = stall;
    assign mem.mem_req   = mem_req;
    assign mem.mem_we    = mem_we;
    assign mem.mem_addr  = mem_addr;
    assign mem.mem_wdata = rd_data;

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed table, reset-abort and handshake sequences, random traffic.
module tb_dcache;
    import dcache_pkg::*;

    localparam int NS = DEF_SETS;
    localparam int LW = DEF_LINE_WORDS;
    localparam int LINE_BYTES = 4 * LW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_cpu_if cpu ();
    dcache_mem_if mem ();

    dcache #(.SETS(NS), .LINE_WORDS(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu.slave),
        .mem   (mem.master)
    );

    int checks   = 0;
    int failures = 0;
    int ready_mode = 0;   // 0: always ready, 1: ready every second cycle, 2: random

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;
    beat_t log_q[$];

    logic [31:0] mem_store [logic [31:0]];   // backing memory
    logic [31:0] arch      [logic [31:0]];   // value a load must return
    bit          dir_valid [NS];
    bit          dir_dirty [NS];
    int unsigned dir_tag   [NS];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : init_val(a);
    endfunction

    function automatic logic [31:0] arch_read(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Main memory: picks mem_ready at the falling edge, applies the beat it accepts.
    int          waiting = 0;
    logic [31:0] held_addr, held_wdata;
    logic        held_we;
    initial begin
        mem.mem_ready = 1'b0;
        mem.mem_rdata = '0;
    end
    always @(negedge clk) begin
        logic rdy;
        if (mem.mem_req === 1'b1) begin
            if (waiting != 0) begin
                check("hold_addr", mem.mem_addr, held_addr);
                check("hold_we", {31'b0, mem.mem_we}, {31'b0, held_we});
                if (held_we) check("hold_wdata", mem.mem_wdata, held_wdata);
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (waiting != 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            mem.mem_ready = rdy;
            if (rdy) begin
                mem.mem_rdata = mem.mem_we ? 32'hBAD0_BAD0 : mem_read(mem.mem_addr);
                log_q.push_back('{we: mem.mem_we, addr: mem.mem_addr, data: mem.mem_wdata});
                if (mem.mem_we) mem_store[mem.mem_addr] = mem.mem_wdata;
                waiting = 0;
            end else begin
                mem.mem_rdata = 32'hBAD0_0000 ^ $urandom;
                waiting    = 1;
                held_addr  = mem.mem_addr;
                held_we    = mem.mem_we;
                held_wdata = mem.mem_wdata;
            end
        end else begin
            waiting       = 0;
            mem.mem_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem.mem_rdata = $urandom;
        end
    end

    // One request from the memory stage; entered and left at posedge+1.
    task automatic access(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int stalls);
        log_q.delete();
        cpu.Wen = we; cpu.Ren = re; cpu.Addr = a; cpu.WriteData = d;
        stalls = 0;
        #1;
        while (cpu.Stall === 1'b1 && stalls < 300) begin
            stalls++;
            @(posedge clk); #2;
        end
        if (cpu.Stall !== 1'b0) begin
            checks++; failures++;
            $display("FAIL stall_timeout addr=%h got stall=%b required 0", a, cpu.Stall);
        end
        rd = cpu.ReadData;
        @(posedge clk); #1;
        cpu.Wen = 1'b0; cpu.Ren = 1'b0;
    endtask

    // Reference: predict hit/miss, bus beats, stall length and load data from the cache rules.
    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rd, input int stalls);
        int unsigned s   = (a / LINE_BYTES) % NS;
        int unsigned tg  = a / (LINE_BYTES * NS);
        logic [31:0] base = a - (a % LINE_BYTES);
        bit          hit = dir_valid[s] && dir_tag[s] == tg;
        bit          wb  = !hit && dir_valid[s] && dir_dirty[s];
        beat_t       exp_q[$];
        int          lines;
        if (!hit) begin
            if (wb) begin
                for (int w = 0; w < LW; w++) begin
                    logic [31:0] va = dir_tag[s] * (LINE_BYTES * NS) + s * LINE_BYTES + w * 4;
                    exp_q.push_back('{we: 1'b1, addr: va, data: arch_read(va)});
                end
            end
            for (int w = 0; w < LW; w++)
                exp_q.push_back('{we: 1'b0, addr: base + w * 4, data: 32'h0});
            dir_valid[s] = 1; dir_tag[s] = tg; dir_dirty[s] = 0;
        end
        check("beat_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check("beat_we", {31'b0, log_q[i].we}, {31'b0, exp_q[i].we});
            check("beat_addr", log_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) check("beat_wdata", log_q[i].data, exp_q[i].data);
        end
        lines = wb ? 2 : 1;
        if (hit)                  check("stall_hit", stalls, 0);
        else if (ready_mode == 0) check("stall_miss", stalls, 1 + LW * lines);
        else if (ready_mode == 1) check("stall_miss_toggle", stalls, 1 + 2 * LW * lines);
        else                      check("stall_miss_min", {31'b0, stalls >= 1 + LW * lines}, 1);
        if (we) begin
            arch[a] = d;
            dir_dirty[s] = 1;
        end else begin
            check("load_data", rd, arch_read(a));
        end
    endtask

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_stalls;
    } vec_t;
    vec_t vecs[$];

    initial begin : main
        logic [31:0] rd;
        int          st;

        cpu.Wen = 0; cpu.Ren = 0; cpu.Addr = 0; cpu.WriteData = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_stall", {31'b0, cpu.Stall}, 0);
        check("rst_mem_req", {31'b0, mem.mem_req}, 0);
        check("rst_mem_we", {31'b0, mem.mem_we}, 0);

        vecs.push_back('{0, 1, 32'h40,  0,            init_val(32'h40),  1 + LW});
        vecs.push_back('{1, 0, 32'h44,  32'hDEADBEEF, 0,                 0});
        vecs.push_back('{0, 1, 32'h44,  0,            32'hDEADBEEF,      0});
        vecs.push_back('{0, 1, 32'h440, 0,            init_val(32'h440), 1 + 2 * LW});
        vecs.push_back('{0, 1, 32'h44,  0,            32'hDEADBEEF,      1 + LW});
        vecs.push_back('{1, 0, 32'h80,  32'hCAFE0001, 0,                 1 + LW});
        vecs.push_back('{0, 1, 32'h80,  0,            32'hCAFE0001,      0});
        vecs.push_back('{0, 1, 32'h880, 0,            init_val(32'h880), 1 + 2 * LW});
        vecs.push_back('{1, 1, 32'h884, 32'h12345678, 0,                 0});
        vecs.push_back('{0, 1, 32'h884, 0,            32'h12345678,      0});
        vecs.push_back('{0, 1, 32'h88,  0,            init_val(32'h88),  1 + 2 * LW});

        ready_mode = 0;
        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, rd, st);
            check($sformatf("vec%0d_stalls", i), st, vecs[i].exp_stalls);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            model_step(vecs[i].we | (vecs[i].we & vecs[i].re), vecs[i].addr,
                       vecs[i].wdata, rd, st);
        end

        // Reset on the second refill beat aborts the line.
        log_q.delete();
        cpu.Ren = 1'b1; cpu.Addr = 32'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_req_before", {31'b0, mem.mem_req}, 1);
        check("abort_addr_beat2", mem.mem_addr, 32'h104);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_req_after", {31'b0, mem.mem_req}, 0);
        reset = 1'b0; cpu.Ren = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < NS; s++) begin dir_valid[s] = 0; dir_dirty[s] = 0; end
        arch = mem_store;
        access(0, 1, 32'h100, 0, rd, st);
        model_step(0, 32'h100, 0, rd, st);

        // Half-rate memory: every beat waits one cycle with the address held.
        ready_mode = 1;
        access(0, 1, 32'h200, 0, rd, st);
        model_step(0, 32'h200, 0, rd, st);
        access(1, 0, 32'h204, 32'h0BAD_F00D, rd, st);
        model_step(1, 32'h204, 32'h0BAD_F00D, rd, st);
        access(0, 1, 32'h1200, 0, rd, st);
        model_step(0, 32'h1200, 0, rd, st);

        // Random traffic over a few conflicting tags.
        ready_mode = 2;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d;
            logic        we, re;
            a  = $urandom_range(0, 3) * (LINE_BYTES * NS) + $urandom_range(0, NS - 1) * LINE_BYTES
                 + $urandom_range(0, LW - 1) * 4;
            d  = $urandom;
            we = 1'($urandom_range(0, 1));
            re = we ? ($urandom_range(0, 7) == 0) : 1'b1;
            access(we, re, a, d, rd, st);
            model_step(we, a, d, rd, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
